r_fifo_slave_to_axi: RTL

Asynchronous FIFO for the AXI read-data (R) channel, carrying beats from a slave's clock domain (write side, `wclk`) to the AXI interconnect clock domain (read side, `rclk`). Read bursts need more than two entries in flight, so the depth is parameterised (power of two) and the pointers cross domains as Gray codes through 2-flop synchronizers. The read side is first-word-fall-through, so the interconnect's R mux can drive `rdata` directly while `rempty` is low.

---
 rtl/axi_fifo_pkg.sv | 48 ++++
 rtl/r_fifo_slave_to_axi_sync_2ff.sv | 24 ++
 rtl/r_fifo_slave_to_axi.sv | 121 ++++++++++++
 3 files changed

// File: rtl/axi_fifo_pkg.sv
// Shared AXI FIFO definitions: R-channel field widths, payload layout and Gray-code helpers
// used by the clock-domain-crossing pointer logic.
package axi_fifo_pkg;

  localparam int R_ID_W      = 8;
  localparam int R_DATA_W    = 32;
  localparam int R_RESP_W    = 2;
  localparam int R_PAYLOAD_W = R_ID_W + R_DATA_W + R_RESP_W + 1;

  // Widest pointer (AW+1 bits) the helpers below can convert.
  localparam int PTR_MAX_W = 16;

  typedef struct packed {
    logic [R_ID_W-1:0]   id;
    logic [R_DATA_W-1:0] data;
    logic [R_RESP_W-1:0] resp;
    logic                last;
  } r_payload_t;

  function automatic logic [PTR_MAX_W-1:0] ptr_mask(input int aw);
    logic [PTR_MAX_W-1:0] m;
    for (int i = 0; i < PTR_MAX_W; i++) begin
      m[i] = (i <= aw);
    end
    return m;
  endfunction

  // Pointers are aw+1 bits wide; bits above the pointer are forced to zero.
  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b,
                                                    input int aw);
    logic [PTR_MAX_W-1:0] bm;
    bm = b & ptr_mask(aw);
    return bm ^ (bm >> 1);
  endfunction

  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g,
                                                    input int aw);
    logic [PTR_MAX_W-1:0] gm;
    logic [PTR_MAX_W-1:0] b;
    gm = g & ptr_mask(aw);
    b[PTR_MAX_W-1] = gm[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ gm[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/r_fifo_slave_to_axi_sync_2ff.sv
// Two-flop synchronizer for Gray-coded pointers crossing into the clk domain; resets to 0.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_p0;

  // Stage p0 captures the foreign-domain value, q is the settled copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '0;
      q       <= '0;
    end else begin
      sync_p0 <= d;
      q       <= sync_p0;
    end
  end

endmodule

// File: rtl/r_fifo_slave_to_axi.sv
// Async FWFT FIFO carrying AXI R beats from the slave clock (wclk) to the interconnect clock
// (rclk). Optional registered almost-full flag when R_FIFO_AFULL_EN is defined. DEPTH must be 2^n.
module r_fifo_slave_to_axi
  import axi_fifo_pkg::*;
#(
  parameter int DATA_W = R_PAYLOAD_W,
  parameter int DEPTH  = 4
`ifdef R_FIFO_AFULL_EN
  , parameter int AFULL_THRESH = DEPTH - 1
`endif
) (
  input  logic              wclk,
  input  logic              wrst,
  input  logic              rclk,
  input  logic              rrst,
  input  logic              wpush,
  input  logic [DATA_W-1:0] wdata,
  output logic              wfull,
`ifdef R_FIFO_AFULL_EN
  output logic              walmost_full,
`endif
  input  logic              rpop,
  output logic [DATA_W-1:0] rdata,
  output logic              rempty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  // Full when write Gray pointer equals read Gray pointer with its top two bits inverted.
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (AW - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PW-1:0] wbin;
  logic [PW-1:0] wgray;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rgray_s;
  logic          wpush_ok;

  logic [PW-1:0] rbin;
  logic [PW-1:0] rgray;
  logic [PW-1:0] rbin_next;
  logic [PW-1:0] rgray_next;
  logic [PW-1:0] wgray_s;
  logic          rpop_ok;

  // Write domain: accept, store and advance.
  assign wpush_ok   = wpush && !wfull;
  assign wbin_next  = wbin + PW'(wpush_ok);
  assign wgray_next = PW'(bin2gray(PTR_MAX_W'(wbin_next), AW));

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin  <= '0;
      wgray <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wpush_ok) begin
        mem[wbin[AW-1:0]] <= wdata;
      end
      wbin  <= wbin_next;
      wgray <= wgray_next;
    end
  end

  assign wfull = (wgray == (rgray_s ^ FULL_MASK));

  // Read domain: first-word-fall-through head and pointer advance.
  assign rpop_ok    = rpop && !rempty;
  assign rbin_next  = rbin + PW'(rpop_ok);
  assign rgray_next = PW'(bin2gray(PTR_MAX_W'(rbin_next), AW));

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin  <= '0;
      rgray <= '0;
    end else begin
      rbin  <= rbin_next;
      rgray <= rgray_next;
    end
  end

  assign rempty = (rgray == wgray_s);
  assign rdata  = mem[rbin[AW-1:0]];

  sync_2ff #(.WIDTH(PW)) u_sync_w2r (
    .clk (rclk),
    .rst (rrst),
    .d   (wgray),
    .q   (wgray_s)
  );

  sync_2ff #(.WIDTH(PW)) u_sync_r2w (
    .clk (wclk),
    .rst (wrst),
    .d   (rgray),
    .q   (rgray_s)
  );

`ifdef R_FIFO_AFULL_EN
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] wocc_next;

  // Occupancy includes the push accepted this cycle; the read side is seen late, so
  // the flag can only clear late, never assert late.
  assign rbin_s    = PW'(gray2bin(PTR_MAX_W'(rgray_s), AW));
  assign wocc_next = wbin_next - rbin_s;

  always_ff @(posedge wclk) begin
    if (wrst) begin
      walmost_full <= 1'b0;
    end else begin
      walmost_full <= (int'(wocc_next) >= AFULL_THRESH);
    end
  end
`endif

endmodule
